// File: rtl/multicycle_control_if.sv
// Control-unit interface: instruction/memory status in, datapath strobes and selects out.
interface multicycle_control_if;
  logic [31:0] instructionWord;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, memWrite, IRWrite;
  logic        MemToReg, RegDst, regWrite, ALUSrcA, Link, illegal_op;
  logic [1:0]  ALUSrcB, PCSource;
  logic [3:0]  ALUControl;
  logic [3:0]  state;

  modport master (
    input  instructionWord, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, memWrite, IRWrite,
    output MemToReg, RegDst, regWrite, ALUSrcA, Link, illegal_op,
    output ALUSrcB, PCSource, ALUControl, state
  );

  modport slave (
    output instructionWord, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, memWrite, IRWrite,
    input  MemToReg, RegDst, regWrite, ALUSrcA, Link, illegal_op,
    input  ALUSrcB, PCSource, ALUControl, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM; one state per cycle, 3-5 cycles per instruction.
// FETCH, MEM_RD and MEM_WR hold while mem_ready is low; outputs decode from the state register.
module multicycle_control (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2, MEM_RD = 4'd3,
    MEM_WB   = 4'd4,  MEM_WR = 4'd5,  R_EXE    = 4'd6, R_WB   = 4'd7,
    BEQ      = 4'd8,  I_EXE  = 4'd9,  I_WB     = 4'd10, JAL   = 4'd11,
    JR       = 4'd12
  } state_t;

  state_t     stateQ;
  state_t     decodeNext;
  logic       decodeIllegal;
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode    = bus.instructionWord[31:26];
  assign funct     = bus.instructionWord[5:0];
  assign bus.state = stateQ;

  always_comb begin
    decodeNext    = FETCH;
    decodeIllegal = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b001000: decodeNext = JR;
          6'b100000, 6'b100010, 6'b100100, 6'b100101,
          6'b100110, 6'b000000, 6'b000010, 6'b011000: decodeNext = R_EXE;
          default: decodeIllegal = 1'b1;
        endcase
      end
      6'b100011, 6'b101011: decodeNext = MEM_ADDR;
      6'b000100:            decodeNext = BEQ;
      6'b001000:            decodeNext = I_EXE;
      6'b000011:            decodeNext = JAL;
      default:              decodeIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= FETCH;
    end else begin
      case (stateQ)
        FETCH:    if (bus.mem_ready) stateQ <= DECODE;
        DECODE:   stateQ <= decodeNext;
        MEM_ADDR: stateQ <= (opcode == 6'b101011) ? MEM_WR : MEM_RD;
        MEM_RD:   if (bus.mem_ready) stateQ <= MEM_WB;
        MEM_WR:   if (bus.mem_ready) stateQ <= FETCH;
        R_EXE:    stateQ <= R_WB;
        I_EXE:    stateQ <= I_WB;
        default:  stateQ <= FETCH;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.regWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.Link        = 1'b0;
    bus.illegal_op  = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.ALUControl  = 4'b0000;
    case (stateQ)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE: begin
        bus.ALUSrcB    = 2'b11;
        bus.illegal_op = decodeIllegal;
      end
      MEM_ADDR, I_EXE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEM_WB: begin
        bus.regWrite = 1'b1;
        bus.MemToReg = 1'b1;
      end
      MEM_WR: begin
        bus.memWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      R_EXE: begin
        bus.ALUSrcA = 1'b1;
        case (funct)
          6'b100010: bus.ALUControl = 4'b0001;
          6'b100100: bus.ALUControl = 4'b0010;
          6'b100101: bus.ALUControl = 4'b0011;
          6'b100110: bus.ALUControl = 4'b0100;
          6'b000000: bus.ALUControl = 4'b0101;
          6'b000010: bus.ALUControl = 4'b0110;
          6'b011000: bus.ALUControl = 4'b0111;
          default:   bus.ALUControl = 4'b0000;
        endcase
      end
      R_WB: begin
        bus.regWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      BEQ: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUControl  = 4'b0001;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      I_WB: bus.regWrite = 1'b1;
      JAL: begin
        bus.regWrite = 1'b1;
        bus.Link     = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      JR: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b11;
      end
      default: ;
    endcase
    // Reset must not let a half-finished instruction write anything.
    if (reset) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.memWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.regWrite    = 1'b0;
      bus.illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams vs a table model.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    bit rdy;
  } step_t;

  logic [5:0] aluFuncts [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b000000, 6'b000010, 6'b011000};
  logic [5:0] knownOps  [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b001000, 6'b000011};

  logic [23:0] obs;
  assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.memWrite,
                bus.IRWrite, bus.MemToReg, bus.RegDst, bus.regWrite, bus.ALUSrcA,
                bus.Link, bus.illegal_op, bus.ALUSrcB, bus.PCSource, bus.ALUControl,
                bus.state};

  function automatic logic [3:0] aluOf(logic [5:0] fn);
    for (int i = 0; i < 8; i++)
      if (aluFuncts[i] == fn) return 4'(i);
    return 4'd0;
  endfunction

  function automatic bit isLegal(logic [31:0] ir);
    if (ir[31:26] == 6'b000000) begin
      if (ir[5:0] == 6'b001000) return 1'b1;
      for (int i = 0; i < 8; i++)
        if (aluFuncts[i] == ir[5:0]) return 1'b1;
      return 1'b0;
    end
    for (int i = 1; i < 6; i++)
      if (knownOps[i] == ir[31:26]) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs for a state, written straight from the per-state output table.
  function automatic logic [23:0] expOut(int st, logic [31:0] ir, bit rdy, bit rst);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, lnk, ill;
    logic [1:0] bsel, psrc;
    logic [3:0] alu;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, lnk, ill} = '0;
    bsel = 2'b00; psrc = 2'b00; alu = 4'b0000;
    case (st)
      0:  begin mr = 1; bsel = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin bsel = 2'b11; ill = !isLegal(ir); end
      2:  begin asa = 1; bsel = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; alu = aluOf(ir[5:0]); end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; alu = 4'b0001; pcwc = 1; psrc = 2'b01; end
      9:  begin asa = 1; bsel = 2'b10; end
      10: rw = 1;
      11: begin rw = 1; lnk = 1; pcw = 1; psrc = 2'b10; end
      12: begin pcw = 1; psrc = 2'b11; end
      default: ;
    endcase
    if (rst) {pcw, pcwc, mw, irw, rw, ill} = '0;
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, lnk, ill,
            bsel, psrc, alu, 4'(st)};
  endfunction

  task automatic chk(string tag, logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Build the state trace of one instruction from its class and stall counts, then
  // drive and check every cycle of it.
  task automatic runInstr(string tag, logic [31:0] ir, int stallF, int stallM);
    step_t q[$];
    logic [5:0] op;
    op = ir[31:26];
    for (int i = 0; i < stallF; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom)});
    if (isLegal(ir)) begin
      if (op == 6'b000000 && ir[5:0] == 6'b001000) q.push_back('{12, 1'($urandom)});
      else if (op == 6'b000000) begin
        q.push_back('{6, 1'($urandom)});
        q.push_back('{7, 1'($urandom)});
      end else if (op == 6'b100011) begin
        q.push_back('{2, 1'($urandom)});
        for (int i = 0; i < stallM; i++) q.push_back('{3, 1'b0});
        q.push_back('{3, 1'b1});
        q.push_back('{4, 1'($urandom)});
      end else if (op == 6'b101011) begin
        q.push_back('{2, 1'($urandom)});
        for (int i = 0; i < stallM; i++) q.push_back('{5, 1'b0});
        q.push_back('{5, 1'b1});
      end else if (op == 6'b000100) q.push_back('{8, 1'($urandom)});
      else if (op == 6'b001000) begin
        q.push_back('{9, 1'($urandom)});
        q.push_back('{10, 1'($urandom)});
      end else q.push_back('{11, 1'($urandom)});
    end
    bus.instructionWord = ir;
    foreach (q[i]) begin
      bus.mem_ready = q[i].rdy;
      #4;
      chk($sformatf("%s_c%0d", tag, i), expOut(q[i].st, ir, q[i].rdy, 1'b0));
      @(posedge clk);
      #1;
    end
    total++;
    assert (bus.state === 4'd0) else begin
      bad++;
      $error("FAIL %s_ret observed=%0d expected=0", tag, bus.state);
    end
  endtask

  initial begin
    logic [31:0] ir;
    logic [31:0] r;
    logic [5:0]  op;
    logic [5:0]  fn;
    bit          badOp;

    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.instructionWord = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    #1;
    chk("reset_state", expOut(0, 32'h0, 1'b1, 1'b1));
    bus.mem_ready = 1'b0;
    reset = 1'b0;

    runInstr("add",     32'h00221820, 0, 0);
    runInstr("lw_wait", 32'h8C220004, 0, 2);
    runInstr("sw_wait", 32'hAC220008, 1, 1);
    runInstr("beq",     32'h10220003, 0, 0);
    runInstr("jal",     32'h0C000040, 0, 0);
    runInstr("jr",      32'h03E00008, 0, 0);
    runInstr("ill_op",  32'hFC000000, 0, 0);
    runInstr("ill_fn",  32'h0022183F, 0, 0);
    runInstr("addi",    32'h2022FFFF, 2, 0);
    runInstr("mul",     32'h00221818, 0, 0);

    // Reset landing in the middle of a stalled store.
    ir = 32'hAC22000C;
    bus.instructionWord = ir;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_wr_pre", expOut(5, ir, 1'b0, 1'b0));
    reset = 1'b1;
    #1;
    chk("rst_wr_during", expOut(5, ir, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_wr_after", expOut(0, ir, 1'b0, 1'b0));
    @(posedge clk);
    #1;

    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      badOp = ($urandom_range(0, 9) == 0);
      op = badOp ? 6'($urandom) : knownOps[$urandom_range(0, 5)];
      if (op == 6'b000000 && $urandom_range(0, 2) != 0) begin
        fn = ($urandom_range(0, 8) == 8) ? 6'b001000 : aluFuncts[$urandom_range(0, 7)];
      end else begin
        fn = r[5:0];
      end
      ir = {op, r[25:6], fn};
      runInstr($sformatf("rnd%0d", n), ir, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
